// File: rtl/bus_arbiter16.sv
// rtl/bus_arbiter16.sv - round-robin sequencer for the shared 16-bit internal data bus
//
// Purpose: grants one of NSRC bus sources at a time by driving the one-hot
// output_en strobes of their tribuf16 drivers, reads the resolved bus back
// and captures each transferred word, and counts completed transfers.
//
// Configuration macro: BUS_DEADCYCLE_EN
//   defined   - a TURN cycle (all drive_en low) separates grants to different
//               sources so two tristate drivers never overlap.
//   undefined - handoffs between sources are back-to-back.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   NSRC   per-source transfer request (level)
//   drive_en   out  NSRC   one-hot-or-zero driver enable
//   ack        out  NSRC   identical to drive_en
//   bus_in     in   WIDTH  resolved shared bus, read back
//   cap_data   out  WIDTH  captured bus word
//   cap_src    out  3      source index of cap_data
//   cap_valid  out  1      one-cycle pulse qualifying cap_data/cap_src
//   busy       out  1      high while in DRIVE or TURN
//   xfer_cnt   out  16     completed transfers since reset, wrapping

module bus_arbiter16 #(
  parameter int NSRC  = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSRC-1:0]  req,
  output logic [NSRC-1:0]  drive_en,
  output logic [NSRC-1:0]  ack,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] cap_data,
  output logic [2:0]       cap_src,
  output logic             cap_valid,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

`ifdef BUS_DEADCYCLE_EN
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRIVE} state_t;
`endif

  state_t             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [NSRC-1:0]    drive_en_q, drive_en_d;
  logic [WIDTH-1:0]   cap_data_q, cap_data_d;
  logic [2:0]         cap_src_q, cap_src_d;
  logic               cap_valid_q, cap_valid_d;
  logic               busy_q, busy_d;
  logic [15:0]        xfer_cnt_q, xfer_cnt_d;

  logic [7:0]         req_ext;
  logic               win_valid;
  logic [2:0]         win_idx;
  logic               do_grant;

  // Modular add within 0..NSRC-1; both operands are already below NSRC,
  // so a single conditional subtract is enough.
  function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'(NSRC)) s = s - 4'(NSRC);
    return s[2:0];
  endfunction

  // Round-robin pick: walk from lowest to highest priority so the last hit,
  // i.e. the one closest to the pointer, wins. Non-existent sources read 0.
  always_comb begin
    req_ext = '0;
    req_ext[NSRC-1:0] = req;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_ext[rr_add(ptr_q, 3'(i))]) begin
        win_valid = 1'b1;
        win_idx   = rr_add(ptr_q, 3'(i));
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      drive_en_q  <= '0;
      cap_data_q  <= '0;
      cap_src_q   <= '0;
      cap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      drive_en_q  <= drive_en_d;
      cap_data_q  <= cap_data_d;
      cap_src_q   <= cap_src_d;
      cap_valid_q <= cap_valid_d;
      busy_q      <= busy_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  // Next state; do_grant marks every entry into DRIVE.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d  = S_DRIVE;
          do_grant = 1'b1;
        end
      end
      S_DRIVE: begin
        if (!win_valid) begin
          state_d = S_IDLE;
        end else if (win_idx == grant_q) begin
          state_d  = S_DRIVE;
          do_grant = 1'b1;
        end else begin
`ifdef BUS_DEADCYCLE_EN
          state_d = S_TURN;
`else
          state_d  = S_DRIVE;
          do_grant = 1'b1;
`endif
        end
      end
`ifdef BUS_DEADCYCLE_EN
      S_TURN: begin
        if (win_valid) begin
          state_d  = S_DRIVE;
          do_grant = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values. The word on the bus during a DRIVE cycle is
  // captured at the edge that ends it.
  always_comb begin
    drive_en_d  = '0;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (do_grant) begin
      grant_d = win_idx;
      ptr_d   = rr_add(win_idx, 3'd1);
      for (int i = 0; i < NSRC; i++) begin
        drive_en_d[i] = (win_idx == 3'(i));
      end
    end
    cap_valid_d = (state_q == S_DRIVE);
    cap_data_d  = cap_data_q;
    cap_src_d   = cap_src_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (state_q == S_DRIVE) begin
      cap_data_d = bus_in;
      cap_src_d  = grant_q;
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
    busy_d = (state_d != S_IDLE);
  end

  assign drive_en  = drive_en_q;
  assign ack       = drive_en_q;
  assign cap_data  = cap_data_q;
  assign cap_src   = cap_src_q;
  assign cap_valid = cap_valid_q;
  assign busy      = busy_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_bus_arbiter16.sv
// tb/tb_bus_arbiter16.sv - scoreboard bench for bus_arbiter16

module tb_bus_arbiter16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  drive_en;
  logic [3:0]  ack;
  logic [15:0] bus_in;
  logic [15:0] cap_data;
  logic [2:0]  cap_src;
  logic        cap_valid;
  logic        busy;
  logic [15:0] xfer_cnt;

  bus_arbiter16 #(.NSRC(4), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .drive_en  (drive_en),
    .ack       (ack),
    .bus_in    (bus_in),
    .cap_data  (cap_data),
    .cap_src   (cap_src),
    .cap_valid (cap_valid),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source words; bus_in models the tribuf16 drivers resolved onto one bus.
  logic [15:0] src_data [4];
  always_comb begin
    bus_in = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (drive_en[i]) bus_in = src_data[i];
    end
  end

  typedef struct packed {
    logic [2:0]  src;
    logic [15:0] data;
    logic [15:0] cnt;
  } cap_t;

  cap_t        sb_q[$];
  cap_t        mon_e;
  logic [15:0] exp_cnt;
  logic        sb_en;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int src);
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back({3'(src), src_data[src], exp_cnt});
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] exp);
    check_eq({tag, "_drive_en"}, 32'(drive_en), 32'(exp));
    check_eq({tag, "_ack"}, 32'(ack), 32'(exp));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq({tag, "_sb_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 16'h0000;
  endtask

  // Expected grant source for cycle t of a continuous 1111 request from reset.
  function automatic int rr_src(input int t);
`ifdef BUS_DEADCYCLE_EN
    return (t / 2) % 4;
`else
    return t % 4;
`endif
  endfunction

  function automatic logic rr_gap(input int t);
`ifdef BUS_DEADCYCLE_EN
    return (t % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  a_onehot0: assert property (@(negedge clk) disable iff (!rst_n) $onehot0(drive_en))
    else $error("FAIL a_onehot0 drive_en=%b", drive_en);

  // Capture monitor: every cap_valid pulse pops one expected entry.
  always @(negedge clk) begin
    if (rst_n) check_eq("onehot0", 32'($onehot0(drive_en)), 32'd1);
    if (cap_valid && sb_en) begin
      if (sb_q.size() == 0) begin
        check_eq("cap_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("cap_data", 32'(cap_data), 32'(mon_e.data));
        check_eq("cap_src", 32'(cap_src), 32'(mon_e.src));
        check_eq("xfer_cnt", 32'(xfer_cnt), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] pat;
    int         ncyc;
    one      = 4'b0001;
    n_checks = 0;
    n_errors = 0;
    sb_en    = 1'b1;
    exp_cnt  = 16'h0000;
    rst_n    = 1'b0;
    req      = 4'b0000;
    for (int i = 0; i < 4; i++) src_data[i] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    expect_grant("rst", 4'b0000);
    check_eq("rst_cap_valid", 32'(cap_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cap_data", 32'(cap_data), 32'h0);
    check_eq("rst_cap_src", 32'(cap_src), 32'h0);
    check_eq("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;

    // Single one-cycle request from source 0
    src_data[0] = 16'hBEEF;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    expect_grant("t1", 4'b0001);
    check_eq("t1_busy", 32'(busy), 32'd1);
    push_exp(0);
    req = 4'b0000;
    @(negedge clk);
    expect_grant("t1_idle", 4'b0000);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);
    drain("t1");

    // All four sources requesting continuously
    do_reset();
    for (int i = 0; i < 4; i++) src_data[i] = 16'hA000 + 16'(i) * 16'h0111;
`ifdef BUS_DEADCYCLE_EN
    ncyc = 9;
`else
    ncyc = 8;
`endif
    @(negedge clk);
    req = 4'b1111;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      pat = rr_gap(t) ? 4'b0000 : (one << rr_src(t));
      expect_grant($sformatf("rr%0d", t), pat);
      if (!rr_gap(t)) push_exp(rr_src(t));
      if (t == ncyc - 1) req = 4'b0000;
    end
    @(negedge clk);
    expect_grant("rr_idle", 4'b0000);
    drain("rr");

    // Source 2 alone for five cycles: back-to-back, no TURN
    do_reset();
    src_data[2] = 16'h5A5A;
    @(negedge clk);
    req = 4'b0100;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      expect_grant($sformatf("hold%0d", t), 4'b0100);
      push_exp(2);
      if (t == 4) req = 4'b0000;
    end
    @(negedge clk);
    expect_grant("hold_idle", 4'b0000);
    drain("hold");

    // Counter wrap: 65535 transfers, then one more
    do_reset();
    sb_en = 1'b0;
    src_data[0] = 16'h0F0F;
    @(negedge clk);
    req = 4'b0001;
    repeat (65535) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check_eq("wrap_ffff", 32'(xfer_cnt), 32'h0000FFFF);
    @(negedge clk);
    sb_en   = 1'b1;
    exp_cnt = 16'hFFFF;
    req     = 4'b0001;
    @(negedge clk);
    expect_grant("wrap", 4'b0001);
    push_exp(0);
    req = 4'b0000;
    drain("wrap");

    // Asynchronous reset in the middle of a DRIVE cycle
    do_reset();
    src_data[1] = 16'h1111;
    src_data[3] = 16'h3333;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    expect_grant("mid", 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    expect_grant("mid_rst", 4'b0000);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cap_valid", 32'(cap_valid), 32'd0);
    check_eq("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    req = 4'b0000;
    @(negedge clk);
    check_eq("mid_no_cap", 32'(cap_valid), 32'd0);
    rst_n   = 1'b1;
    exp_cnt = 16'h0000;
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    expect_grant("post_rst_first", 4'b0010);
    push_exp(1);
    req = 4'b1000;
`ifdef BUS_DEADCYCLE_EN
    @(negedge clk);
    expect_grant("post_rst_turn", 4'b0000);
`endif
    @(negedge clk);
    expect_grant("post_rst_second", 4'b1000);
    push_exp(3);
    req = 4'b0000;
    @(negedge clk);
    expect_grant("post_rst_idle", 4'b0000);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter16.md
# bus_arbiter16

Sequencer for the shared 16-bit internal data bus. It arbitrates round-robin among up to eight bus sources and drives the one-hot `output_en` strobes of their `tribuf16` bus drivers, never more than one at a time. It reads the resolved bus back and captures each transferred word for the consuming stage. A post-reset transfer counter is also provided.

## Interface
Parameters:
- `NSRC`, 4 — number of bus sources; legal range 2..8.
- `WIDTH`, 16 — bus width; matches the `tribuf16` drivers.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  NSRC  per-source transfer request; level, sampled on `clk`.
- `drive_en`  out  NSRC  one-hot-or-zero driver enable; bit i goes to source i's `tribuf16` `output_en`.
- `ack`  out  NSRC  one-hot-or-zero; `ack[i]` is identical to `drive_en[i]`.
- `bus_in`  in  WIDTH  resolved shared bus, read back.
- `cap_data`  out  WIDTH  word captured from the bus.
- `cap_src`  out  3  index of the source that drove `cap_data`.
- `cap_valid`  out  1  one-cycle pulse qualifying `cap_data`/`cap_src`.
- `busy`  out  1  high in DRIVE or TURN.
- `xfer_cnt`  out  16  completed transfers since reset; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, DRIVE, TURN. All outputs are registered.
- IDLE: all `drive_en` are 0.
  - If any `req` is high, go to DRIVE and grant the winner.
- DRIVE: exactly one `drive_en[g]` is high, for one cycle; one transfer is one word.
  - At the end of this cycle, `bus_in` is captured into `cap_data`, g into `cap_src`, and `xfer_cnt` increments.
  - The next state is chosen from the sampled `req`, with bit g treated as a new request:
    - no request → IDLE;
    - winner equals g → DRIVE again, back-to-back;
    - winner differs from g → TURN when `BUS_DEADCYCLE_EN` is defined, else DRIVE with the new grant.
- TURN: all `drive_en` are 0 for one cycle, so the bus is released.
  - Next state is DRIVE, granting the winner chosen from `req` sampled at the end of TURN.
  - If no request remains, next state is IDLE.
- Round-robin arbitration:
  - Priority starts at index (last granted + 1) mod NSRC.
  - After reset the pointer makes index 0 highest priority.
  - The pointer updates only on entry to DRIVE.
- Request handshake: a source holds `req` until it sees `ack`.
  - A `req` still high in the cycle after `ack` is a new request.
- Bits of `req` at or above `NSRC` do not exist; `cap_src` is zero-extended.
- `cap_data` and `cap_src` hold their value between pulses.
- Reset, including assertion mid-transfer:
  - `drive_en`, `ack`, `cap_valid` and `busy` go to 0 immediately (asynchronous), releasing the bus.
  - `cap_data` and `xfer_cnt` reset to 0x0000; `cap_src` resets to 0.
  - State goes to IDLE and the pointer resets to index 0.
  - A transfer interrupted by reset is not captured or counted.

## Timing
- `req[i]` sampled high at edge k with the bus idle → `drive_en[i]`/`ack[i]` high during cycle k+1.
- `cap_valid` is high in the cycle after the DRIVE cycle, which is cycle k+2.
- `xfer_cnt` shows the new value in that same cycle.
- Source change with `BUS_DEADCYCLE_EN` defined: one zero cycle of `drive_en` between grants; throughput is 1 word per 2 cycles.
- Same source, or macro undefined: 1 word per cycle.
- `drive_en` never has more than one bit set in any cycle; this is checked by assertion in the bench.
- The bus value must be valid in the DRIVE cycle at least setup time before the capturing edge. The tristate path is combinational.

## Configuration
- `BUS_DEADCYCLE_EN` defined: the TURN state is compiled in. A driver handoff between different sources inserts one all-zero `drive_en` cycle to prevent bus contention during tristate turn-off.
- Not defined: the TURN state is absent and handoffs are back-to-back. For targets whose tristates are mapped to muxes.

## Test plan
- Reset then `req`=0001 held 1 cycle → `drive_en`=0001 one cycle later; bus 0xBEEF → `cap_valid` pulse with `cap_data`=0xBEEF, `cap_src`=0, `xfer_cnt`=1.
- `req`=1111 held continuously, macro defined → grants 0,1,2,3,0…, each separated by one all-zero `drive_en` cycle; `xfer_cnt` +1 per 2 cycles.
- Same stimulus, macro undefined → grants 0,1,2,3 on consecutive cycles with no gap; `xfer_cnt` +4 in 4 cycles.
- `req`=0100 held alone for 5 cycles → `drive_en`=0100 for 5 consecutive cycles with no TURN; 5 captures.
- Preload `xfer_cnt`=0xFFFF via 65535 transfers, then one more → `xfer_cnt`=0x0000.
- Assert `rst_n`=0 asynchronously mid-DRIVE → `drive_en`=0 before the next edge, no `cap_valid`, `xfer_cnt`=0. After release, `req`=1010 → source 1 granted first.
